// File: rtl/rvvi_flow_ctrl.sv
// Flow-control scheduler for the hardware RVVI trace link: counts frames sent to the MAC,
// parses 9-word host acknowledgement frames and requests a core stall on backlog or host load.
module rvvi_flow_ctrl #(
  parameter logic [31:0] WINDOW      = 32'd8,
  parameter logic [31:0] LOAD_THRESH = 32'd1000,
  parameter logic [31:0] TIMEOUT     = 32'd100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Enable,
  input  logic        TxFrameDone,
  input  logic [31:0] RxTdata,
  input  logic        RxTvalid,
  input  logic        RxTlast,
  output logic        ExternalStall,
  output logic [31:0] Outstanding,
  output logic [31:0] HostLoad,
  output logic        AckTimeout,
  output logic [15:0] RejectCount
);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} rxState_t;

  rxState_t    rxState;
  logic [3:0]  beatIdx;
  logic [31:0] sentCount;
  logic [31:0] ackedCount;
  logic [31:0] ackN;
  logic [31:0] timeoutCnt;
  logic [31:0] newAcked;
  logic [31:0] ackDist;
  logic        evaluate;
  logic        accept;
  logic        reject;

  assign Outstanding   = sentCount - ackedCount;
  assign ExternalStall = Enable & ((Outstanding >= WINDOW) | (HostLoad > LOAD_THRESH));

  // An ack advances iff its distance behind SentCount is strictly smaller than the
  // current backlog; modular subtraction keeps this valid across counter wrap.
  always_comb begin
    newAcked = ackN + 32'd1;
    ackDist  = sentCount - newAcked;
    evaluate = (rxState == RECV) && RxTvalid && RxTlast && (beatIdx == 4'd8);
    accept   = evaluate && (ackDist < Outstanding);
    reject   = RxTvalid && RxTlast && !accept;
  end

  // beatIdx holds the index of the beat currently on the bus while in RECV.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxState <= IDLE;
      beatIdx <= '0;
      ackN    <= '0;
    end else if (RxTvalid) begin
      case (rxState)
        IDLE: begin
          beatIdx <= 4'd1;
          if (!RxTlast) rxState <= RECV;
        end
        RECV: begin
          if (beatIdx == 4'd4) ackN <= RxTdata;
          if (RxTlast)              rxState <= IDLE;
          else if (beatIdx == 4'd8) rxState <= DISCARD;
          else                      beatIdx <= beatIdx + 4'd1;
        end
        DISCARD: begin
          if (RxTlast) rxState <= IDLE;
        end
        default: rxState <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sentCount   <= '0;
      ackedCount  <= '0;
      HostLoad    <= '0;
      RejectCount <= '0;
      timeoutCnt  <= '0;
      AckTimeout  <= 1'b0;
    end else begin
      sentCount   <= sentCount + 32'(TxFrameDone);
      ackedCount  <= accept ? newAcked : ackedCount;
      HostLoad    <= accept ? RxTdata : HostLoad;
      RejectCount <= (reject && (RejectCount != '1)) ? RejectCount + 16'd1 : RejectCount;
      if (accept || (Outstanding == '0)) begin
        timeoutCnt <= '0;
      end else if (timeoutCnt != TIMEOUT) begin
        timeoutCnt <= timeoutCnt + 32'd1;
      end
      if (accept) begin
        AckTimeout <= 1'b0;
      end else if ((Outstanding != '0) && (timeoutCnt != TIMEOUT) &&
                   (timeoutCnt + 32'd1 == TIMEOUT)) begin
        AckTimeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rvvi_flow_ctrl.sv
// Directed bench for rvvi_flow_ctrl: a table of pulse/ack steps with expected outputs,
// plus hand sequences for stall timing, same-cycle send/ack, wrap, timeout and saturation.
module tb_rvvi_flow_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        Enable;
  logic        TxFrameDone;
  logic [31:0] RxTdata;
  logic        RxTvalid;
  logic        RxTlast;
  logic        ExternalStall;
  logic [31:0] Outstanding;
  logic [31:0] HostLoad;
  logic        AckTimeout;
  logic [15:0] RejectCount;

  int nChecks = 0;
  int nFails  = 0;

  rvvi_flow_ctrl #(
    .WINDOW     (32'd8),
    .LOAD_THRESH(32'd1000),
    .TIMEOUT    (32'd50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Enable       (Enable),
    .TxFrameDone  (TxFrameDone),
    .RxTdata      (RxTdata),
    .RxTvalid     (RxTvalid),
    .RxTlast      (RxTlast),
    .ExternalStall(ExternalStall),
    .Outstanding  (Outstanding),
    .HostLoad     (HostLoad),
    .AckTimeout   (AckTimeout),
    .RejectCount  (RejectCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pulses;
    int          beats;
    logic [31:0] ackN;
    logic [31:0] load;
    logic [31:0] expOut;
    logic [31:0] expLoad;
    logic [15:0] expRej;
    logic        expStall;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      TxFrameDone = 1'b1;
      @(negedge clk);
    end
    TxFrameDone = 1'b0;
  endtask

  task automatic beat(input logic [31:0] data, input logic last);
    RxTvalid = 1'b1;
    RxTdata  = data;
    RxTlast  = last;
    @(negedge clk);
    RxTvalid = 1'b0;
    RxTlast  = 1'b0;
  endtask

  // One idle cycle is inserted before beat 2 so only valid beats get counted.
  task automatic sendFrame(input int nBeats, input logic [31:0] n, input logic [31:0] load,
                           input logic txOnLast);
    for (int b = 0; b < nBeats; b++) begin
      if (b == 2) begin
        RxTdata = 32'hDEADBEEF;
        @(negedge clk);
      end
      if (b == nBeats - 1) TxFrameDone = txOnLast;
      beat((b == 4) ? n : (b == 8) ? load : 32'hA5A50000 + 32'(b), b == nBeats - 1);
      TxFrameDone = 1'b0;
    end
  endtask

  initial begin
    reset       = 1'b1;
    Enable      = 1'b1;
    TxFrameDone = 1'b0;
    RxTdata     = '0;
    RxTvalid    = 1'b0;
    RxTlast     = 1'b0;

    vecs[0] = '{8, 0, 32'd0,  32'd0,    32'd8, 32'd0,    16'd0, 1'b1};
    vecs[1] = '{0, 9, 32'd3,  32'd5,    32'd4, 32'd5,    16'd0, 1'b0};
    vecs[2] = '{0, 9, 32'd3,  32'd6,    32'd4, 32'd5,    16'd1, 1'b0};
    vecs[3] = '{0, 8, 32'd5,  32'd6,    32'd4, 32'd5,    16'd2, 1'b0};
    vecs[4] = '{0, 10, 32'd5, 32'd6,    32'd4, 32'd5,    16'd3, 1'b0};
    vecs[5] = '{0, 9, 32'd9,  32'd6,    32'd4, 32'd5,    16'd4, 1'b0};
    vecs[6] = '{0, 1, 32'd0,  32'd0,    32'd4, 32'd5,    16'd5, 1'b0};
    vecs[7] = '{0, 9, 32'd7,  32'd1001, 32'd0, 32'd1001, 16'd5, 1'b1};
    vecs[8] = '{0, 9, 32'd7,  32'd1000, 32'd0, 32'd1001, 16'd6, 1'b1};
    vecs[9] = '{3, 9, 32'd10, 32'd1000, 32'd0, 32'd1000, 16'd6, 1'b0};

    @(negedge clk);
    doReset();
    check("reset Outstanding", Outstanding, 32'd0);
    check("reset HostLoad", HostLoad, 32'd0);
    check("reset AckTimeout", 32'(AckTimeout), 32'd0);
    check("reset RejectCount", 32'(RejectCount), 32'd0);
    check("reset ExternalStall", 32'(ExternalStall), 32'd0);

    for (int i = 0; i < 10; i++) begin
      pulses(vecs[i].pulses);
      if (vecs[i].beats > 0) sendFrame(vecs[i].beats, vecs[i].ackN, vecs[i].load, 1'b0);
      check($sformatf("vec%0d Outstanding", i), Outstanding, vecs[i].expOut);
      check($sformatf("vec%0d HostLoad", i), HostLoad, vecs[i].expLoad);
      check($sformatf("vec%0d RejectCount", i), 32'(RejectCount), 32'(vecs[i].expRej));
      check($sformatf("vec%0d ExternalStall", i), 32'(ExternalStall), 32'(vecs[i].expStall));
    end

    // Stall edge timing around WINDOW
    doReset();
    pulses(7);
    check("window-1 stall", 32'(ExternalStall), 32'd0);
    pulses(1);
    check("window stall", 32'(ExternalStall), 32'd1);
    sendFrame(9, 32'd3, 32'd5, 1'b0);
    check("release stall", 32'(ExternalStall), 32'd0);
    check("release Outstanding", Outstanding, 32'd4);

    // TxFrameDone coincident with an accepting tlast
    doReset();
    pulses(1);
    sendFrame(9, 32'd0, 32'd7, 1'b1);
    check("simul sentCount", dut.sentCount, 32'd2);
    check("simul ackedCount", dut.ackedCount, 32'd1);
    check("simul Outstanding", Outstanding, 32'd1);
    check("simul HostLoad", HostLoad, 32'd7);

    // Counter wrap
    doReset();
    force dut.sentCount  = 32'hFFFFFFFF;
    force dut.ackedCount = 32'hFFFFFFFE;
    @(posedge clk);
    #1;
    release dut.sentCount;
    release dut.ackedCount;
    @(negedge clk);
    pulses(1);
    check("wrap Outstanding", Outstanding, 32'd2);
    sendFrame(9, 32'hFFFFFFFE, 32'd1, 1'b0);
    check("wrap ack1 Outstanding", Outstanding, 32'd1);
    sendFrame(9, 32'hFFFFFFFD, 32'd1, 1'b0);
    check("wrap stale RejectCount", 32'(RejectCount), 32'd1);
    sendFrame(9, 32'hFFFFFFFF, 32'd1, 1'b0);
    check("wrap ack2 ackedCount", dut.ackedCount, 32'd0);
    check("wrap ack2 Outstanding", Outstanding, 32'd0);

    // Ack timeout, load stall and Enable gating
    doReset();
    pulses(1);
    repeat (49) @(negedge clk);
    check("timeout cycle49", 32'(AckTimeout), 32'd0);
    @(negedge clk);
    check("timeout cycle50", 32'(AckTimeout), 32'd1);
    repeat (10) @(negedge clk);
    check("timeout held", 32'(AckTimeout), 32'd1);
    sendFrame(9, 32'd0, 32'd2000, 1'b0);
    check("timeout cleared", 32'(AckTimeout), 32'd0);
    check("load stall", 32'(ExternalStall), 32'd1);
    Enable = 1'b0;
    #1;
    check("enable gate", 32'(ExternalStall), 32'd0);
    Enable = 1'b1;

    // Reset mid-frame leaves a tail that is rejected as a short frame
    doReset();
    for (int b = 0; b < 5; b++) beat(32'd0, 1'b0);
    doReset();
    for (int b = 0; b < 4; b++) beat(32'd0, b == 3);
    check("midreset RejectCount", 32'(RejectCount), 32'd1);
    check("midreset Outstanding", Outstanding, 32'd0);

    // RejectCount saturation
    doReset();
    force dut.RejectCount = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.RejectCount;
    @(negedge clk);
    beat(32'd0, 1'b1);
    check("reject to max", 32'(RejectCount), 32'hFFFF);
    beat(32'd0, 1'b1);
    check("reject saturate", 32'(RejectCount), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
